// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_responder_pkg;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    // Counter holds at most LATENCY-1; keep it at least one bit wide.
    function automatic int cnt_width(input int lat);
        return (lat < 3) ? 1 : $clog2(lat);
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between MEM-stage adapter and responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_wea;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (output req_valid, req_we, req_wea, req_addr, req_wdata, rsp_ready,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_wea, req_addr, req_wdata, rsp_ready,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Moves low-aligned store lanes/data up to the byte offset and load data back down.
module dmem_responder_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [3:0]  wea,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  lane_mask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_sh,
    output logic        align_err
);
    assign lane_mask = wea << off;
    assign wdata_sh  = wdata << {off, 3'b000};
    assign rdata_sh  = rword >> {off, 3'b000};

    always_comb begin
        align_err = 1'b1;
        case (wea)
            BE_BYTE: align_err = 1'b0;
            BE_HALF: align_err = off[0];
            BE_WORD: align_err = (off != 2'b00);
            default: align_err = 1'b1;
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rstn,
    dmem_responder_if.slave bus
);
    localparam int CW = cnt_width(LATENCY);
    localparam int AW = $clog2(DEPTH);

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];

    logic          accept, in_range, align_err, err_c;
    logic [AW-1:0] idx;
    logic [31:0]   rword, wdata_sh, rdata_sh;
    logic [3:0]    lane_mask;

    assign accept   = (state == IDLE) && bus.req_valid;
    assign in_range = {2'b00, bus.req_addr[31:2]} < 32'(DEPTH);
    assign idx      = bus.req_addr[AW+1:2];
    assign rword    = in_range ? mem[idx] : 32'h0;
    assign err_c    = !in_range || (bus.req_we && align_err);

    dmem_responder_lane_align u_align (
        .off       (bus.req_addr[1:0]),
        .wea       (bus.req_wea),
        .wdata     (bus.req_wdata),
        .rword     (rword),
        .lane_mask (lane_mask),
        .wdata_sh  (wdata_sh),
        .rdata_sh  (rdata_sh),
        .align_err (align_err)
    );

    // Array is deliberately outside the reset domain: committed stores survive rstn.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !err_c)
            for (int i = 0; i < 4; i++)
                if (lane_mask[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                rdata_q <= (bus.req_we || err_c) ? 32'h0 : rdata_sh;
                err_q   <= err_c;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.req_valid) begin
                if (LATENCY == 1) state_n = RESP;
                else begin
                    state_n = WAIT;
                    cnt_n   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) state_n = RESP;
            end
            RESP: if (bus.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
